scalar_mult_ctrl: RTL
=====================

# scalar_mult_ctrl

Sequencer for Ed25519 scalar multiplication Q = k·P on top of the shared extended-coordinate point engine, which provides the initial-conversion, doubling and addition operations. The block runs left-to-right double-and-add over a 255-bit scalar. It issues one engine operation at a time through the engine's start/finished handshake and keeps the base point and the accumulator between operations. It sits between the signature top-level FSM and the point engine, and is the only driver of the engine's inputs.

## Interface
- No parameters; widths are fixed at 255-bit field elements.
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high; clock i_clk
- i_start  in  1  request pulse; sampled only in IDLE
- i_scalar  in  255  scalar k, latched on accept
- i_px, i_py  in  255 each  affine base point, latched on accept
- o_busy  out  1  high from accept until the o_done cycle inclusive
- o_done  out  1  one-cycle completion pulse
- o_zero  out  1  valid with o_done; 1 when k==0, in which case the coordinate outputs are 0
- o_x, o_y, o_z, o_t  out  255 each  result in extended coordinates; held until the next accept
- o_pa_start  out  1  one-cycle engine start pulse
- o_pa_doubling, o_pa_initial  out  1 each  engine mode; both 0 means addition
- o_pa_x1, o_pa_y1, o_pa_z1, o_pa_t1, o_pa_x2, o_pa_y2, o_pa_z2, o_pa_t2  out  255 each  engine operands
- i_pa_x3, i_pa_y3, i_pa_z3, i_pa_t3  in  255 each  engine results
- i_pa_finished  in  1  engine done pulse; results are valid in the same cycle

## Operation
- Registers:
  - k_r: latched scalar.
  - idx_r: 8-bit bit index.
  - P_r: base point (X,Y,Z,T).
  - Q_r: accumulator (X,Y,Z,T).
  - state_r.
- States: IDLE, SCAN, ISS_INIT, W_INIT, ISS_DBL, W_DBL, ISS_ADD, W_ADD, DONE.
- IDLE: on i_start, latch k, px, py.
  - k==0: go to DONE with zero_r=1.
  - Otherwise: zero_r=0, idx=254, go to SCAN.
- SCAN: each cycle inspects k_r[idx_r].
  - Bit set: go to ISS_INIT.
  - Bit clear: decrement idx. No underflow is possible because k≠0.
- ISS_INIT: start=1, initial=1, x1=px, y1=py, all other operands 0. Go to W_INIT.
- W_INIT: on i_pa_finished, P_r ← result and Q_r ← result.
  - idx==0: go to DONE.
  - Otherwise: idx−1, go to ISS_DBL.
- ISS_DBL: start=1, doubling=1, operand set 1 = Q_r, operand set 2 = 0. Go to W_DBL.
- W_DBL: on i_pa_finished, Q_r ← result.
  - k_r[idx]=1: go to ISS_ADD.
  - idx==0: go to DONE.
  - Otherwise: idx−1, go to ISS_DBL.
- ISS_ADD: start=1, both mode bits 0, operand set 1 = Q_r, operand set 2 = P_r. Go to W_ADD.
- W_ADD: on i_pa_finished, Q_r ← result.
  - idx==0: go to DONE.
  - Otherwise: idx−1, go to ISS_DBL.
- DONE: o_done=1, o_zero=zero_r, o_x..o_t ← Q_r (or 0 if zero_r). Go to IDLE.
- i_start is ignored in every state other than IDLE, including DONE.
- i_pa_finished outside a W_* state is ignored.
- Operation count for a scalar with MSB at position m and popcount w: 1 init + m doublings + (w−1) additions.

## Timing
- Reset values:
  - state IDLE; idx 0; all data registers 0.
  - o_busy=0, o_done=0, o_zero=0.
  - o_x, o_y, o_z, o_t = 0.
  - o_pa_start=0; both mode bits 0; all engine operands 0.
- The engine shares i_rst, so a reset mid-operation returns both blocks to idle in the same cycle. No partial result is emitted.
- All outputs are registered.
- o_pa_start is high exactly one cycle per ISS_* state.
- Operands and mode bits stay stable from the start cycle until i_pa_finished.
- A new start is issued no earlier than the cycle after i_pa_finished, because ISS_* follows W_*.
- Let cycle 0 be the cycle in which i_start is accepted and L be the engine latency from o_pa_start to i_pa_finished:
  - SCAN occupies 255−m cycles.
  - Each operation costs L+1 cycles (ISS + wait).
  - o_done is asserted at cycle 1 + (255−m) + (ops)·(L+1).
- k==0: o_done at cycle 1, o_busy high for cycles 1..1.
- o_busy goes high in cycle 1 and low the cycle after o_done.

## Test plan
- k=0, P arbitrary → o_done at cycle 1 with o_zero=1, coordinates 0, zero engine starts.
- k=1, bench engine model with L=3 → exactly one start (initial=1, x1=px, y1=py); o_done at cycle 1+255+4=260; Q equals the init result.
- k=5 (binary 101) → mode sequence INIT, DBL, DBL, ADD; the ADD's operand set 2 equals the stored P; 4 starts total.
- k=2^254 → 1 INIT then 254 DBL, no ADD; SCAN lasts 1 cycle.
- k=2^255−1 → 1 INIT, 254 DBL, 254 ADD strictly alternating DBL/ADD. i_start pulsed repeatedly while busy is ignored, and a spurious i_pa_finished in SCAN is ignored.
- Assert i_rst during W_DBL → next cycle state is IDLE, o_pa_start=0, all outputs 0. A fresh k=3 then completes with sequence INIT, DBL, ADD.

Source files
------------

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for Ed25519 scalar multiplication Q = k*P,
// driving the shared extended-coordinate point engine one operation at a time.
module scalar_mult_ctrl (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [254:0] i_scalar,
    input  logic [254:0] i_px,
    input  logic [254:0] i_py,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_zero,
    output logic [254:0] o_x,
    output logic [254:0] o_y,
    output logic [254:0] o_z,
    output logic [254:0] o_t,
    output logic         o_pa_start,
    output logic         o_pa_doubling,
    output logic         o_pa_initial,
    output logic [254:0] o_pa_x1,
    output logic [254:0] o_pa_y1,
    output logic [254:0] o_pa_z1,
    output logic [254:0] o_pa_t1,
    output logic [254:0] o_pa_x2,
    output logic [254:0] o_pa_y2,
    output logic [254:0] o_pa_z2,
    output logic [254:0] o_pa_t2,
    input  logic [254:0] i_pa_x3,
    input  logic [254:0] i_pa_y3,
    input  logic [254:0] i_pa_z3,
    input  logic [254:0] i_pa_t3,
    input  logic         i_pa_finished
);

    // state    | meaning
    // IDLE     | waiting for i_start
    // SCAN     | skipping leading zero bits of k
    // ISS_INIT | start pulse for affine-to-extended conversion of P
    // W_INIT   | waiting for conversion result
    // ISS_DBL  | start pulse for Q = 2Q
    // W_DBL    | waiting for doubling result
    // ISS_ADD  | start pulse for Q = Q + P
    // W_ADD    | waiting for addition result
    // DONE     | result presented with o_done
    typedef enum logic [3:0] {
        IDLE, SCAN, ISS_INIT, W_INIT, ISS_DBL, W_DBL, ISS_ADD, W_ADD, DONE
    } state_t;

    typedef struct packed {
        logic [254:0] x;
        logic [254:0] y;
        logic [254:0] z;
        logic [254:0] t;
    } point_t;

    state_t       state_r;
    logic [254:0] k_r;
    logic [7:0]   idx_r;
    point_t       p_r;
    point_t       q_r;
    point_t       op1_r;
    point_t       op2_r;
    point_t       out_r;
    point_t       res;

    assign res = {i_pa_x3, i_pa_y3, i_pa_z3, i_pa_t3};

    assign {o_x, o_y, o_z, o_t}                 = out_r;
    assign {o_pa_x1, o_pa_y1, o_pa_z1, o_pa_t1} = op1_r;
    assign {o_pa_x2, o_pa_y2, o_pa_z2, o_pa_t2} = op2_r;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r       <= IDLE;
            k_r           <= '0;
            idx_r         <= '0;
            p_r           <= '0;
            q_r           <= '0;
            op1_r         <= '0;
            op2_r         <= '0;
            out_r         <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_zero        <= 1'b0;
            o_pa_start    <= 1'b0;
            o_pa_doubling <= 1'b0;
            o_pa_initial  <= 1'b0;
        end else begin
            o_done     <= 1'b0;
            o_pa_start <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_start) begin
                        k_r    <= i_scalar;
                        p_r    <= {i_px, i_py, 510'd0};
                        q_r    <= '0;
                        o_busy <= 1'b1;
                        if (i_scalar == '0) begin
                            o_zero  <= 1'b1;
                            o_done  <= 1'b1;
                            out_r   <= '0;
                            state_r <= DONE;
                        end else begin
                            idx_r   <= 8'd254;
                            state_r <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (k_r[idx_r]) begin
                        // p_r still holds (px, py, 0, 0) here
                        o_pa_start    <= 1'b1;
                        o_pa_initial  <= 1'b1;
                        o_pa_doubling <= 1'b0;
                        op1_r         <= p_r;
                        op2_r         <= '0;
                        state_r       <= ISS_INIT;
                    end else begin
                        idx_r <= idx_r - 8'd1;
                    end
                end
                ISS_INIT: state_r <= W_INIT;
                ISS_DBL:  state_r <= W_DBL;
                ISS_ADD:  state_r <= W_ADD;
                W_INIT, W_DBL, W_ADD: begin
                    if (i_pa_finished) begin
                        q_r <= res;
                        if (state_r == W_INIT) p_r <= res;
                        if (state_r == W_DBL && k_r[idx_r]) begin
                            o_pa_start    <= 1'b1;
                            o_pa_initial  <= 1'b0;
                            o_pa_doubling <= 1'b0;
                            op1_r         <= res;
                            op2_r         <= p_r;
                            state_r       <= ISS_ADD;
                        end else if (idx_r == 8'd0) begin
                            o_done  <= 1'b1;
                            o_zero  <= 1'b0;
                            out_r   <= res;
                            state_r <= DONE;
                        end else begin
                            idx_r         <= idx_r - 8'd1;
                            o_pa_start    <= 1'b1;
                            o_pa_initial  <= 1'b0;
                            o_pa_doubling <= 1'b1;
                            op1_r         <= res;
                            op2_r         <= '0;
                            state_r       <= ISS_DBL;
                        end
                    end
                end
                DONE: begin
                    o_busy  <= 1'b0;
                    state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
